stopwatch_lap: RTL and testbench
================================

# stopwatch_lap

Parametrised BCD stopwatch and countdown timer with a configurable tick prescaler, digit count and top-digit radix. It adds load, count-down with done flag, lap/split display freeze and a wrap indication. It sits between the board clock and the seven-segment display driver, and supersedes the fixed 4-digit up-only stopwatch.

## Interface
- TICK_DIV, 1000000: clk cycles per count tick (≥2); 1000000 gives 0.01 s at 100 MHz
- TICK_W, 20: prescaler width; must satisfy 2^TICK_W ≥ TICK_DIV
- NUM_DIGITS, 4: number of BCD digits (≥2)
- TOP_RADIX, 6: radix of the most significant digit (2..10); all lower digits are radix 10
---
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = prescaler advances
- clear  in  1  sync; zeroes count, prescaler, lap freeze, done, wrap
- load  in  1  sync; loads load_value into count
- load_value  in  4*NUM_DIGITS  BCD preset; nibble i is digit i (digit 0 = LSD)
- mode_down  in  1  0 = count up, 1 = count down
- lap  in  1  single-cycle pulse; toggles display freeze
- digits  out  4*NUM_DIGITS  displayed BCD value (live or frozen)
- frozen  out  1  1 = display holds lap capture
- done  out  1  sticky; count-down reached zero
- wrap  out  1  one-cycle pulse; up-count wrapped from max to zero

## Operation
- Prescaler p:
  - when run=1, p increments modulo TICK_DIV
  - tick = run & (p == TICK_DIV-1)
  - run=0 holds p
- Live count: array of NUM_DIGITS BCD nibbles.
- Up mode, on tick:
  - increment with full carry resolved in the same edge
  - digit i < NUM_DIGITS-1 rolls 9→0; top digit rolls TOP_RADIX-1→0
  - all-max → all-zero, and wrap pulses
- Down mode, on tick:
  - decrement with borrow; a borrowing lower digit reloads 9
  - count == 0: tick is ignored and the count holds 0
  - the transition to 0 sets done
- Load:
  - count ← load_value, with each nibble clamped to its radix-1 (lower digits to 9, top digit to TOP_RADIX-1)
  - p ← 0; done ← 0
- Clear: count, p, done, frozen, lap register ← 0.
- Priority per edge: clear > load > tick. A tick coinciding with load or clear is discarded.
- Lap:
  - lap=1 with frozen=0: lap register ← current registered live count; frozen ← 1
  - lap=1 with frozen=1: frozen ← 0
  - lap is ignored when clear=1; lap with load captures the pre-load count
- digits = frozen ? lap register : live count. The live count keeps running while frozen.
- mode_down may change at any time and takes effect at the next tick. done stays set across a mode change until load or clear.
- Reset (async, reset_n=0): all state and outputs to 0 immediately. Mid-tick reset loses the partial prescale.

## Timing
- All outputs are registered. Reset values: digits=0, frozen=0, done=0, wrap=0.
- Tick latency:
  - run held high from p=0: first count change on the TICK_DIV-th rising edge
  - the change is visible on digits immediately after that edge
- wrap and done assert on the same edge the count wraps or reaches 0. wrap deasserts on the next edge.
- Load and clear take effect on the edge where they are sampled. Consecutive ticks are exactly TICK_DIV run-cycles apart after a load.
- lap to frozen display: 1 edge. Toggle pulses on consecutive cycles alternate freeze/release.
- Deassertion of reset_n is synchronised by the top-level reset synchroniser, not inside this block.

## Test plan
All scenarios use TICK_DIV=4, NUM_DIGITS=4, TOP_RADIX=6.
- **Up count:** reset, run=1 for 40 cycles → digits=0x0010; done=0, wrap never set.
- **Wrap:** load 0x5999, up, run 4 cycles → digits=0x0000, wrap high exactly 1 cycle.
- **Countdown:** load 0x0102, mode_down=1, run 4 cycles → digits=0x0101. Run to 0 → done=1; 8 more cycles → digits stays 0x0000. Then load 0x0001 → done=0.
- **Lap:** up from 0, lap pulse at count 0x0003 → digits=0x0003, frozen=1 while live advances. Lap again at live 0x0007 → digits=0x0007, frozen=0.
- **Clamp/priority:** load 0x7A3F → digits=0x5939. clear and load in the same cycle → digits=0x0000. run=0 for 10 cycles → no change.
- **Async reset:** drop reset_n mid-prescale at count 0x0042, with no clk edge → digits=0, frozen=0, done=0 immediately. After release with run=1 → first tick after 4 cycles.

Source files
------------

// File: rtl/stopwatch_lap.sv
// BCD stopwatch / countdown timer with tick prescaler, load, lap freeze,
// sticky done on reaching zero and a one-cycle wrap pulse on up-count rollover.
module stopwatch_lap #(
  parameter int TICK_DIV   = 1000000,
  parameter int TICK_W     = 20,
  parameter int NUM_DIGITS = 4,
  parameter int TOP_RADIX  = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    mode_down,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    frozen,
  output logic                    done,
  output logic                    wrap
);

  localparam int W = 4 * NUM_DIGITS;
  localparam logic [TICK_W-1:0] P_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [3:0] TOP_MAX = 4'(TOP_RADIX - 1);

  logic [TICK_W-1:0] p_q, p_d;
  logic [W-1:0]      count_q, count_d;
  logic [W-1:0]      lap_q, lap_d;
  logic [W-1:0]      digits_q, digits_d;
  logic              frozen_q, frozen_d;
  logic              done_q, done_d;
  logic              wrap_q, wrap_d;

  logic [W-1:0]      inc_val, dec_val, clamp_val;
  logic              inc_wraps;
  logic              tick;

  assign tick = run && (p_q == P_LAST);

  // Ripple carry/borrow through all digits so a full rollover resolves in one edge.
  always_comb begin
    logic       carry;
    logic       borrow;
    logic [3:0] dig;
    logic [3:0] dmax;
    logic [3:0] ld;
    inc_val   = '0;
    dec_val   = '0;
    clamp_val = '0;
    carry     = 1'b1;
    borrow    = 1'b1;
    dig       = 4'd0;
    dmax      = 4'd0;
    ld        = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig  = count_q[4*i +: 4];
      dmax = (i == NUM_DIGITS - 1) ? TOP_MAX : 4'd9;
      inc_val[4*i +: 4] = dig;
      if (carry) begin
        if (dig >= dmax) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = dig + 4'd1;
          carry = 1'b0;
        end
      end
      dec_val[4*i +: 4] = dig;
      if (borrow) begin
        if (dig == 4'd0) begin
          dec_val[4*i +: 4] = dmax;
        end else begin
          dec_val[4*i +: 4] = dig - 4'd1;
          borrow = 1'b0;
        end
      end
      ld = load_value[4*i +: 4];
      clamp_val[4*i +: 4] = (ld > dmax) ? dmax : ld;
    end
    inc_wraps = carry;
  end

  always_comb begin
    p_d      = p_q;
    count_d  = count_q;
    lap_d    = lap_q;
    frozen_d = frozen_q;
    done_d   = done_q;
    wrap_d   = 1'b0;
    if (clear) begin
      p_d      = '0;
      count_d  = '0;
      lap_d    = '0;
      frozen_d = 1'b0;
      done_d   = 1'b0;
    end else begin
      // Lap samples the registered count, so lap with load freezes the pre-load value.
      if (lap) begin
        if (!frozen_q) begin
          lap_d    = count_q;
          frozen_d = 1'b1;
        end else begin
          frozen_d = 1'b0;
        end
      end
      if (load) begin
        count_d = clamp_val;
        p_d     = '0;
        done_d  = 1'b0;
      end else begin
        if (run) begin
          p_d = (p_q == P_LAST) ? '0 : p_q + TICK_W'(1);
        end
        if (tick) begin
          if (mode_down) begin
            if (count_q != '0) begin
              count_d = dec_val;
              if (dec_val == '0) begin
                done_d = 1'b1;
              end
            end
          end else begin
            count_d = inc_val;
            wrap_d  = inc_wraps;
          end
        end
      end
    end
    digits_d = frozen_d ? lap_d : count_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q      <= '0;
      count_q  <= '0;
      lap_q    <= '0;
      digits_q <= '0;
      frozen_q <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      p_q      <= p_d;
      count_q  <= count_d;
      lap_q    <= lap_d;
      digits_q <= digits_d;
      frozen_q <= frozen_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
    end
  end

  assign digits = digits_q;
  assign frozen = frozen_q;
  assign done   = done_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: a one-edge-per-row vector table plus
// hand-written multi-cycle sequences (up count, countdown to zero, lap, async reset).
module tb_stopwatch_lap;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        clear;
  logic        load;
  logic [15:0] load_value;
  logic        mode_down;
  logic        lap;
  logic [15:0] digits;
  logic        frozen;
  logic        done;
  logic        wrap;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        clear;
    logic        load;
    logic        run;
    logic        mode_down;
    logic        lap;
    logic [15:0] load_value;
    logic [15:0] exp_digits;
    logic        exp_frozen;
    logic        exp_done;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[28];

  stopwatch_lap #(
    .TICK_DIV  (4),
    .TICK_W    (3),
    .NUM_DIGITS(4),
    .TOP_RADIX (6)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .mode_down (mode_down),
    .lap       (lap),
    .digits    (digits),
    .frozen    (frozen),
    .done      (done),
    .wrap      (wrap)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic c, input logic ld, input logic r, input logic md,
                              input logic lp, input logic [15:0] lv, input logic [15:0] ed,
                              input logic ef, input logic edn, input logic ew);
    vec_t v;
    v.clear = c; v.load = ld; v.run = r; v.mode_down = md; v.lap = lp;
    v.load_value = lv; v.exp_digits = ed; v.exp_frozen = ef; v.exp_done = edn; v.exp_wrap = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] ed, input logic ef,
                           input logic edn, input logic ew);
    check({name, ".digits"}, digits, ed);
    check({name, ".frozen"}, {15'd0, frozen}, {15'd0, ef});
    check({name, ".done"},   {15'd0, done},   {15'd0, edn});
    check({name, ".wrap"},   {15'd0, wrap},   {15'd0, ew});
  endtask

  // one rising edge, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    run = 1'b0; clear = 1'b0; load = 1'b0; lap = 1'b0; load_value = 16'h0000;
  endtask

  initial begin
    int wrap_seen;
    reset_n = 1'b0;
    mode_down = 1'b0;
    idle_inputs();

    // table: each row is one edge, starting from count 0x0010, p=0, up mode
    vecs[0]  = mk(0, 1, 0, 0, 0, 16'h5999, 16'h5999, 0, 0, 0);
    vecs[1]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h5999, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h5999, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h5999, 0, 0, 0);
    vecs[4]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 1);
    vecs[5]  = mk(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 0, 16'h7A3F, 16'h5939, 0, 0, 0);
    vecs[7]  = mk(1, 1, 1, 0, 0, 16'h1234, 16'h0000, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    vecs[9]  = mk(0, 1, 0, 1, 0, 16'h0102, 16'h0102, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0102, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0102, 0, 0, 0);
    vecs[12] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0102, 0, 0, 0);
    vecs[13] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0101, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 1, 1, 16'h0000, 16'h0101, 1, 0, 0);
    vecs[15] = mk(0, 1, 0, 1, 1, 16'h0005, 16'h0005, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 1, 1, 16'h0003, 16'h0005, 1, 0, 0);
    vecs[17] = mk(0, 0, 0, 1, 1, 16'h0000, 16'h0003, 0, 0, 0);
    vecs[18] = mk(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 0);
    vecs[19] = mk(0, 1, 1, 1, 0, 16'h0002, 16'h0002, 0, 0, 0);
    vecs[20] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0002, 0, 0, 0);
    vecs[21] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0002, 0, 0, 0);
    vecs[22] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0002, 0, 0, 0);
    vecs[23] = mk(0, 1, 1, 1, 0, 16'h0009, 16'h0009, 0, 0, 0);
    vecs[24] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0009, 0, 0, 0);
    vecs[25] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0009, 0, 0, 0);
    vecs[26] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0009, 0, 0, 0);
    vecs[27] = mk(0, 0, 1, 1, 0, 16'h0000, 16'h0008, 0, 0, 0);

    // reset state
    #12;
    check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    step();

    // up count: 40 run cycles = 10 ticks
    run = 1'b1;
    wrap_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (wrap) wrap_seen++;
    end
    check_all("up40", 16'h0010, 1'b0, 1'b0, 1'b0);
    check("up40.wrap_seen", 16'(wrap_seen), 16'd0);

    // vector table
    for (int i = 0; i < 28; i++) begin
      clear = vecs[i].clear; load = vecs[i].load; run = vecs[i].run;
      mode_down = vecs[i].mode_down; lap = vecs[i].lap; load_value = vecs[i].load_value;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].exp_digits, vecs[i].exp_frozen,
                vecs[i].exp_done, vecs[i].exp_wrap);
    end
    idle_inputs();

    // countdown to zero, hold at zero, done sticky across mode change, cleared by load
    mode_down = 1'b1; load = 1'b1; load_value = 16'h0002;
    step();
    idle_inputs();
    run = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_all("down1", 16'h0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check_all("down0", 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step();
    check_all("down_hold", 16'h0000, 1'b0, 1'b1, 1'b0);
    run = 1'b0; mode_down = 1'b0;
    step();
    check_all("done_sticky", 16'h0000, 1'b0, 1'b1, 1'b0);
    load = 1'b1; load_value = 16'h0001;
    step();
    check_all("load_clr_done", 16'h0001, 1'b0, 1'b0, 1'b0);
    idle_inputs();

    // lap freeze while live count keeps running
    clear = 1'b1;
    step();
    clear = 1'b0; run = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check_all("lap_pre", 16'h0003, 1'b0, 1'b0, 1'b0);
    lap = 1'b1;
    step();
    lap = 1'b0;
    check_all("lap_freeze", 16'h0003, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step();
    check_all("lap_held", 16'h0003, 1'b1, 1'b0, 1'b0);
    lap = 1'b1;
    step();
    lap = 1'b0;
    check_all("lap_release", 16'h0007, 1'b0, 1'b0, 1'b0);

    // async reset mid-prescale with no clock edge
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 168; i++) step();
    check_all("pre_reset", 16'h0042, 1'b0, 1'b0, 1'b0);
    lap = 1'b1;
    step();
    lap = 1'b0;
    step();
    check("pre_reset.frozen", {15'd0, frozen}, 16'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("post_reset3", digits, 16'h0000);
    step();
    check("post_reset4", digits, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
